// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding and response code.
package pcpu;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } Resp_State_t;

    typedef enum logic {
        RESP_OK  = 1'b0,
        RESP_ERR = 1'b1
    } resp_code_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge: each enabled lane takes the write data, the rest keep the old word.
module be_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] new_word
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign new_word[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port word store answering one request at a time after a fixed wait,
// with a one-cycle ready strobe carrying read data and an error flag.
//
// state  | meaning
// S_IDLE | waiting for req; accepts and latches the request
// S_WAIT | counting down the configured wait cycles
// S_RESP | ready=1 with registered rdata/err; write commits on exit
module mem_responder
    import pcpu::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 2**DEPTH_LOG2;

    Resp_State_t            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   we_q;
    logic [31:0]            addr_q, wdata_q;
    logic [3:0]             be_q;
    resp_code_t             code_q, code_nxt;
    logic [31:0]            rdata_nxt;
    logic                   ready_nxt;

    logic [31:0]            mem [DEPTH];

    logic                   accept;
    logic                   src_we;
    logic                   src_ok;
    logic [31:0]            src_addr;
    logic [DEPTH_LOG2-1:0]  src_idx;
    logic [DEPTH_LOG2-1:0]  wr_idx;
    logic                   commit;
    logic [31:0]            merged;

    assign accept = (state == S_IDLE) && req;

    // With zero wait the response is built on the accepting edge, before the latch holds it.
    assign src_addr = accept ? addr : addr_q;
    assign src_we   = accept ? we   : we_q;
    assign src_ok   = ((src_addr >> (DEPTH_LOG2 + 2)) == 32'd0) && (src_addr[1:0] == 2'b00);
    assign src_idx  = src_addr[DEPTH_LOG2+1:2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = 1'b0;
        code_nxt  = RESP_OK;
        rdata_nxt = 32'd0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) state_nxt = S_RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt == S_RESP) begin
            ready_nxt = 1'b1;
            code_nxt  = src_ok ? RESP_OK : RESP_ERR;
            rdata_nxt = (src_ok && !src_we) ? mem[src_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready   <= 1'b0;
            code_q  <= RESP_OK;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ready  <= ready_nxt;
            code_q <= code_nxt;
            rdata  <= rdata_nxt;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
        end
    end

    assign err = (code_q == RESP_ERR);

    assign wr_idx = addr_q[DEPTH_LOG2+1:2];
    assign commit = (state == S_RESP) && we_q && (code_q == RESP_OK);

    be_merge u_be_merge (
        .old_word (mem[wr_idx]),
        .wdata    (wdata_q),
        .be       (be_q),
        .new_word (merged)
    );

    // Storage has no reset; an aborted transaction never reaches S_RESP so never commits.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_idx] <= merged;
    end

endmodule
